// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the 32-bit instruction core.
// Sequences FETCH -> WAIT_MEM -> EXEC -> DELAY -> NEXT, owns the program
// counter, the instruction register and the retired-instruction counter,
// and applies the datapath's jump/halt decisions at the end of each
// instruction. run/step/restart give the host run and single-step control.
module instr_sequencer #(
    parameter int PC_W       = 4,
    parameter int EXEC_DELAY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             restart,
    output logic             imem_rd_en,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             exec_valid,
    input  logic             exec_ready,
    input  logic             jmp_taken,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_EXEC     = 3'd3,
        S_DELAY    = 3'd4,
        S_NEXT     = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    // Delay counter sized for the configured delay; at least one bit so the
    // EXEC_DELAY=0 build still elaborates (the counter is then never used).
    localparam int DLY_W = (EXEC_DELAY > 1) ? $clog2(EXEC_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((EXEC_DELAY > 0) ? EXEC_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_s;
    logic [DLY_W-1:0] dly_cnt_r;
    logic             jmp_r;
    logic             halt_r;
    logic [PC_W-1:0]  pc_r;
    logic [31:0]      ir_r;
    logic [CNT_W-1:0] retired_r;

    logic             imem_rd_en_s;
    logic             exec_valid_s;
    logic             busy_s;
    logic             halted_s;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (restart) begin
                    state_s = S_IDLE;
                end else if (run || step) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                state_s = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                state_s = S_EXEC;
            end
            S_EXEC: begin
                if (!exec_ready) begin
                    state_s = S_EXEC;
                end else if (EXEC_DELAY == 0) begin
                    state_s = S_NEXT;
                end else begin
                    state_s = S_DELAY;
                end
            end
            S_DELAY: begin
                if (dly_cnt_r == DLY_LAST) begin
                    state_s = S_NEXT;
                end else begin
                    state_s = S_DELAY;
                end
            end
            S_NEXT: begin
                if (halt_r) begin
                    state_s = S_HALT;
                end else if (run) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HALT: begin
                if (restart) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_HALT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Strobes decoded straight from the state register.
    always_comb begin
        imem_rd_en_s = 1'b0;
        exec_valid_s = 1'b0;
        busy_s       = 1'b1;
        halted_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy_s = 1'b0;
            end
            S_FETCH: begin
                imem_rd_en_s = 1'b1;
            end
            S_EXEC: begin
                exec_valid_s = 1'b1;
            end
            S_HALT: begin
                busy_s   = 1'b0;
                halted_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Handshake capture of jump/halt decisions and the DELAY cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jmp_r     <= 1'b0;
            halt_r    <= 1'b0;
            dly_cnt_r <= '0;
        end else begin
            case (state_r)
                S_EXEC: begin
                    if (exec_ready) begin
                        jmp_r     <= jmp_taken;
                        halt_r    <= halt_req;
                        dly_cnt_r <= '0;
                    end
                end
                S_DELAY: begin
                    dly_cnt_r <= dly_cnt_r + DLY_W'(1);
                end
                default: begin
                    dly_cnt_r <= dly_cnt_r;
                end
            endcase
        end
    end

    // Architectural state: program counter, instruction register, retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= '0;
            ir_r      <= 32'h0000_0000;
            retired_r <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_HALT: begin
                    if (restart) begin
                        pc_r <= '0;
                    end
                end
                S_WAIT_MEM: begin
                    ir_r <= imem_rdata;
                end
                S_NEXT: begin
                    if (retired_r != CNT_MAX) begin
                        retired_r <= retired_r + CNT_W'(1);
                    end
                    // A halt leaves pc on the halt instruction; halt beats jump.
                    if (halt_r) begin
                        pc_r <= pc_r;
                    end else if (jmp_r) begin
                        pc_r <= ir_r[PC_W-1:0];
                    end else begin
                        pc_r <= pc_r + PC_W'(1);
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign imem_rd_en = imem_rd_en_s;
    assign exec_valid = exec_valid_s;
    assign busy       = busy_s;
    assign halted     = halted_s;
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign ir         = ir_r;
    assign retired    = retired_r;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM that sequences the 32-bit-instruction processor core through fetch, decode/execute, delay, PC update and halt.
- Owns the program counter, the instruction-memory read and the instruction register.
- Hands each instruction to the execute datapath with a valid/ready handshake, and applies the datapath's jump and halt decisions.
- Adds run and single-step control for the bench and debug host.

Parameters:
- PC_W, 4: program counter width; instruction memory depth is 2^PC_W words.
- EXEC_DELAY, 4: cycles spent in DELAY after each execute handshake; 0 skips the DELAY state.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; while high, instructions are executed back-to-back.
- step  in  1  one-cycle pulse; executes exactly one instruction when run=0 and the state is IDLE.
- restart  in  1  one-cycle pulse; sets pc to 0 and returns the FSM to IDLE. Honoured only in IDLE or HALT.
- imem_rd_en  out  1  instruction-memory read strobe.
- imem_addr  out  PC_W  instruction-memory address, always equal to pc.
- imem_rdata  in  32  instruction word, valid one cycle after imem_rd_en.
- ir  out  32  instruction register.
- exec_valid  out  1  ir is presented to the datapath for execution.
- exec_ready  in  1  datapath has accepted and completed the instruction.
- jmp_taken  in  1  datapath jump decision, sampled on the handshake.
- halt_req  in  1  datapath halt decode, sampled on the handshake.
- pc  out  PC_W  current program counter.
- halted  out  1  high while the state is HALT.
- busy  out  1  high in every state except IDLE and HALT.
- retired  out  CNT_W  saturating count of completed instructions.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - pc, ir, retired and every output go to 0.
  - Reset asserted mid-instruction aborts the instruction immediately; no PC update, no count.
- States: IDLE, FETCH, WAIT_MEM, EXEC, DELAY, NEXT, HALT.
- IDLE:
  - restart=1 takes priority: pc<=0, stay in IDLE.
  - Otherwise run=1 or step=1 moves to FETCH.
  - Otherwise stay in IDLE.
- FETCH: imem_rd_en=1 and imem_addr=pc for exactly one cycle, then go to WAIT_MEM.
- WAIT_MEM: ir<=imem_rdata, then go to EXEC.
- EXEC:
  - exec_valid=1, held until exec_ready=1. ir is stable throughout.
  - On the handshake cycle, latch jmp_taken and halt_req internally.
  - Then go to DELAY, or straight to NEXT if EXEC_DELAY=0.
  - The datapath may stall indefinitely by holding exec_ready low.
- DELAY: internal counter runs EXEC_DELAY cycles exactly, is cleared on entry, then the FSM goes to NEXT.
- NEXT (one cycle):
  - retired increments and saturates at all-ones.
  - PC update:
    - halt latched: pc is unchanged (it points at the halt instruction); go to HALT.
    - else jmp latched: pc<=ir[PC_W-1:0] (immediate field truncated).
    - else pc<=pc+1, wrapping modulo 2^PC_W.
  - Next state: run=1 goes to FETCH, run=0 goes to IDLE.
  - Halt has priority over jump when both are latched.
- HALT:
  - halted=1; run and step are ignored.
  - restart sets pc<=0 and goes to IDLE.
  - Leaving HALT otherwise requires rst_n.
- run dropping mid-instruction: the current instruction completes through NEXT, then the FSM returns to IDLE.
- step pulses outside IDLE are ignored; they are not queued.
- Latency with exec_ready tied high:
  - 4 + EXEC_DELAY cycles per instruction, i.e. 8 at the default.
  - FETCH-to-FETCH spacing in run mode is 8 cycles.
- Outputs are registered, except that exec_valid, imem_rd_en, busy and halted are decoded directly from the state register.

Test Plan:
1. Reset mid-EXEC (pc=3, exec_ready=0, drop rst_n) -> all outputs 0 within the same cycle, state IDLE, retired unchanged at 0 after release.
2. Run mode, memory of 16 non-control instructions, exec_ready=1, run held 130 cycles -> FETCH pulses every 8 cycles; pc goes 0..15 then wraps to 0; retired=16 after 128 cycles.
3. Jump: word at address 2 returns jmp_taken=1, ir[3:0]=4'hA -> pc sequence 0,1,2,10,11; no fetch from addresses 3–9.
4. Halt at address 5, with jmp_taken and halt_req both high -> halted=1, pc stays 5, no further imem_rd_en. Then restart pulse -> pc=0, state IDLE, halted=0.
5. Single-step with run=0: one step pulse -> exactly one imem_rd_en, one exec_valid, pc 0->1, back to IDLE. A second step pulse issued while busy is ignored.
6. Stall: exec_ready low for 20 cycles in EXEC -> exec_valid held and ir stable for the whole stall; pc advances only after ready. Repeat with EXEC_DELAY=0 -> 4-cycle instruction spacing.
